// File: rtl/channel_link_in_if.sv
// rtl/channel_link_in_if.sv - link-side and FIFO-side signal bundle for channel_link_in
//
// Purpose: groups the channel-link receive pins, the FWFT FIFO read port and
// the per-event status/counter outputs of channel_link_in.
// Modports:
//   slave  - the receiver (channel_link_in): samples link pins and RD_EN,
//            drives FIFO head, event status and error counters.
//   master - the DCFEB link driver plus downstream event builder.
// Signals:
//   DATAIN[15:0], MB_FIFO_PUSH_B, DATAAVAIL, ENDWORD, MOVLP, OVLPMUX_B : link word + strobes
//   RD_EN                                                   : FIFO pop request
//   DOUT[15:0], DOUT_LAST, DOUT_ERR, DOUT_VALID             : FIFO head
//   EVT_DONE, EVT_WRDS[11:0], EVT_MOVLP                     : closed-event status
//   ORPHAN_CNT, TMO_CNT, OVFL_CNT, MUX_ERR_CNT [7:0]        : saturating error counters

interface channel_link_in_if;
   logic [15:0] DATAIN;
   logic        MB_FIFO_PUSH_B;
   logic        DATAAVAIL;
   logic        ENDWORD;
   logic        MOVLP;
   logic        OVLPMUX_B;
   logic        RD_EN;
   logic [15:0] DOUT;
   logic        DOUT_LAST;
   logic        DOUT_ERR;
   logic        DOUT_VALID;
   logic        EVT_DONE;
   logic [11:0] EVT_WRDS;
   logic        EVT_MOVLP;
   logic [7:0]  ORPHAN_CNT;
   logic [7:0]  TMO_CNT;
   logic [7:0]  OVFL_CNT;
   logic [7:0]  MUX_ERR_CNT;

   modport slave (
      input  DATAIN, MB_FIFO_PUSH_B, DATAAVAIL, ENDWORD, MOVLP, OVLPMUX_B, RD_EN,
      output DOUT, DOUT_LAST, DOUT_ERR, DOUT_VALID, EVT_DONE, EVT_WRDS, EVT_MOVLP,
             ORPHAN_CNT, TMO_CNT, OVFL_CNT, MUX_ERR_CNT
   );

   modport master (
      output DATAIN, MB_FIFO_PUSH_B, DATAAVAIL, ENDWORD, MOVLP, OVLPMUX_B, RD_EN,
      input  DOUT, DOUT_LAST, DOUT_ERR, DOUT_VALID, EVT_DONE, EVT_WRDS, EVT_MOVLP,
             ORPHAN_CNT, TMO_CNT, OVFL_CNT, MUX_ERR_CNT
   );
endinterface

// File: rtl/channel_link_in.sv
// rtl/channel_link_in.sv - DCFEB-to-DMB channel-link receive end with event framing and FWFT FIFO
//
// Purpose: registers the channel-link word and strobes, frames each L1A event
// (IDLE -> ARMED -> RECV -> IDLE, or -> FLUSH on timeout), checks overlap-mux
// consistency, and buffers {data,last,err} in a first-word-fall-through FIFO.
// Ports:
//   CLK  - link clock, all logic on posedge
//   RST  - asynchronous active-high reset
//   link - channel_link_in_if.slave (link inputs, FIFO read port, status, counters)
// Parameters:
//   FIFO_AW - FIFO address width, depth = 2**FIFO_AW
//   TMO_CYC - idle cycles tolerated in ARMED/RECV before the event is flushed (1..4095)

module channel_link_in #(
   parameter int FIFO_AW = 9,
   parameter int TMO_CYC = 1023
) (
   input  logic              CLK,
   input  logic              RST,
   channel_link_in_if.slave  link
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   CNT_RSV  = {1'b0, {FIFO_AW{1'b1}}};
   localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [11:0]        TMO_LAST = 12'(TMO_CYC - 1);
   localparam logic [15:0]        TRAILER  = 16'hDEAD;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RECV,
      S_FLUSH
   } state_t;

   function automatic logic [7:0] inc_sat8(input logic [7:0] v, input logic en);
      return (en && v != 8'hFF) ? v + 8'd1 : v;
   endfunction

   // ---------------- input stage ----------------
   logic [15:0] r_data;
   logic        r_push;
   logic        r_davail;
   logic        r_end;
   logic        r_movlp;
   logic        r_mux_b;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_data   <= '0;
         r_push   <= 1'b0;
         r_davail <= 1'b0;
         r_end    <= 1'b0;
         r_movlp  <= 1'b0;
         r_mux_b  <= 1'b0;
      end else begin
         r_data   <= link.DATAIN;
         r_push   <= ~link.MB_FIFO_PUSH_B;
         r_davail <= link.DATAAVAIL;
         r_end    <= link.ENDWORD;
         r_movlp  <= link.MOVLP;
         r_mux_b  <= link.OVLPMUX_B;
      end
   end

   // ---------------- FIFO storage ----------------
   logic [17:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   cnt;
   logic               fifo_rd;

   // Non-last words stop one slot short of full so the closing word always fits.
   logic room_data;
   logic room_last;
   assign room_data = (cnt < CNT_RSV);
   assign room_last = (cnt != CNT_FULL);
   assign fifo_rd   = link.RD_EN && (cnt != '0);

   // ---------------- event state ----------------
   state_t      state;
   state_t      state_nx;
   logic [11:0] wcnt;
   logic [11:0] timer;
   logic        movlp_acc;
   logic        err_acc;

   logic        mux_bad;
   logic        tmo_hit;
   logic        movlp_now;
   logic [11:0] wcnt_nx;

   assign mux_bad   = r_push && ((~r_mux_b) != r_data[14]);
   assign tmo_hit   = (timer == TMO_LAST);
   assign movlp_now = movlp_acc | ((state != S_IDLE) & r_movlp);

   // next-state / datapath controls
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_last;
   logic        wr_err;
   logic        word_take;
   logic        close_evt;
   logic        flush_wr;
   logic        orphan;
   logic        drop;

   always_comb begin
      state_nx  = state;
      wr_en     = 1'b0;
      wr_data   = r_data;
      wr_last   = 1'b0;
      wr_err    = 1'b0;
      word_take = 1'b0;
      close_evt = 1'b0;
      flush_wr  = 1'b0;
      orphan    = 1'b0;
      case (state)
         S_IDLE: begin
            orphan = r_push;
            if (r_davail) state_nx = S_ARMED;
         end
         S_ARMED, S_RECV: begin
            if (r_push) begin
               word_take = 1'b1;
               state_nx  = S_RECV;
               wr_last   = r_end;
               // err is only meaningful on the closing word
               wr_err    = r_end & (err_acc | mux_bad);
               wr_en     = r_end ? room_last : room_data;
               if (r_end) begin
                  close_evt = 1'b1;
                  state_nx  = S_IDLE;
               end
            end else if (tmo_hit) begin
               state_nx = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // waits here (timer frozen) until the trailer fits
            if (room_last) begin
               wr_en     = 1'b1;
               wr_data   = TRAILER;
               wr_last   = 1'b1;
               wr_err    = 1'b1;
               close_evt = 1'b1;
               flush_wr  = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign drop    = word_take & ~wr_en;
   assign wcnt_nx = (word_take && wcnt != 12'hFFF) ? wcnt + 12'd1 : wcnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nx;
   end

   // per-event accumulators
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wcnt      <= '0;
         timer     <= '0;
         movlp_acc <= 1'b0;
         err_acc   <= 1'b0;
      end else if (state == S_IDLE) begin
         if (r_davail) begin
            wcnt      <= '0;
            timer     <= '0;
            movlp_acc <= 1'b0;
            err_acc   <= 1'b0;
         end
      end else begin
         wcnt      <= wcnt_nx;
         movlp_acc <= movlp_now;
         err_acc   <= err_acc | (word_take & mux_bad) | drop;
         if (state != S_FLUSH) begin
            if (r_push)        timer <= '0;
            else if (!tmo_hit) timer <= timer + 12'd1;
         end
      end
   end

   // event status and error counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         link.EVT_DONE    <= 1'b0;
         link.EVT_WRDS    <= '0;
         link.EVT_MOVLP   <= 1'b0;
         link.ORPHAN_CNT  <= '0;
         link.TMO_CNT     <= '0;
         link.OVFL_CNT    <= '0;
         link.MUX_ERR_CNT <= '0;
      end else begin
         link.EVT_DONE <= close_evt;
         if (close_evt) begin
            link.EVT_WRDS  <= wcnt_nx;
            link.EVT_MOVLP <= movlp_now;
         end
         link.ORPHAN_CNT  <= inc_sat8(link.ORPHAN_CNT, orphan);
         link.TMO_CNT     <= inc_sat8(link.TMO_CNT, flush_wr);
         link.OVFL_CNT    <= inc_sat8(link.OVFL_CNT, drop);
         link.MUX_ERR_CNT <= inc_sat8(link.MUX_ERR_CNT, word_take & mux_bad);
      end
   end

   // ---------------- FIFO pointers and storage ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
         if (fifo_rd) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, fifo_rd})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= {wr_data, wr_last, wr_err};
   end

   // FWFT head; forced to zero when empty so outputs read 0 after reset
   logic [17:0] head;
   assign head            = (cnt != '0) ? mem[rd_ptr] : 18'd0;
   assign link.DOUT       = head[17:2];
   assign link.DOUT_LAST  = head[1];
   assign link.DOUT_ERR   = head[0];
   assign link.DOUT_VALID = (cnt != '0);

endmodule

// File: doc/channel_link_in.md
Name: channel_link_in

Overview:
- Receive end of the DCFEB-to-DMB channel-link word interface, placed on the motherboard side.
- Registers the 16-bit link words and their strobes (active-low push, data-available, end-word, multi-overlap, inverted overlap-mux).
- Frames each L1A event, checks framing and overlap-mux consistency, and buffers words in a first-word-fall-through FIFO for the downstream event builder.
- Reports per-event status and saturating error counters.

Parameters:
- FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW words.
- TMO_CYC, 1023, idle cycles allowed in ARMED/RECV before timeout (max 4095).

Ports:
- CLK  input  1  link clock; all logic on posedge.
- RST  input  1  asynchronous active-high reset.
- DATAIN  input  16  channel-link data word.
- MB_FIFO_PUSH_B  input  1  active-low word-valid strobe.
- DATAAVAIL  input  1  event data available (L1A match).
- ENDWORD  input  1  marks last word of event.
- MOVLP  input  1  multi-overlap flag.
- OVLPMUX_B  input  1  inverted copy of DATAIN[14].
- RD_EN  input  1  pops FIFO head when DOUT_VALID=1.
- DOUT  output  16  FIFO head data.
- DOUT_LAST  output  1  head is last word of event.
- DOUT_ERR  output  1  head word belongs to an errored event (valid with DOUT_LAST).
- DOUT_VALID  output  1  FIFO not empty.
- EVT_DONE  output  1  one-cycle pulse at event close.
- EVT_WRDS  output  12  words received in the closed event, saturating at 4095.
- EVT_MOVLP  output  1  OR of MOVLP over the closed event.
- ORPHAN_CNT  output  8  pushes outside an event; saturating.
- TMO_CNT  output  8  timed-out events; saturating.
- OVFL_CNT  output  8  words dropped on FIFO full; saturating.
- MUX_ERR_CNT  output  8  overlap-mux mismatches; saturating.

Behaviour:
- Reset: all outputs 0, FIFO emptied, state IDLE, all counters 0. Reset mid-event discards the partial event with no trailer.
- Input stage: all link inputs registered once. Every decision below uses the registered copies, so FSM latency is one cycle from the pins. A valid word is registered MB_FIFO_PUSH_B = 0.
- IDLE:
  - DATAAVAIL=1 → ARMED; clear word count, timer and movlp accumulator.
  - Valid word in IDLE is discarded and ORPHAN_CNT increments.
- ARMED:
  - First valid word → RECV; the word is written.
  - If that word also has ENDWORD=1, the event closes immediately.
- RECV:
  - Each valid word is written and increments the word count.
  - Valid word with ENDWORD=1 is written with last=1, then EVT_DONE pulses on the next cycle and the FSM returns to IDLE.
  - ENDWORD without a valid word is ignored.
  - DATAAVAIL while in ARMED/RECV is ignored.
- Timeout: the timer resets on each valid word. When it reaches TMO_CYC in ARMED or RECV, the FSM enters FLUSH:
  - FLUSH writes a trailer word 16'hDEAD with last=1, err=1, increments TMO_CNT, pulses EVT_DONE, then returns to IDLE.
  - If the FIFO is full, FLUSH holds until space is available; the timer is frozen.
- Overlap mux check: on every valid word, a mismatch between ~OVLPMUX_B and DATAIN[14] increments MUX_ERR_CNT and marks the event errored. The word is still written.
- MOVLP: ORed over the ARMED..close window; presented on EVT_MOVLP together with EVT_DONE.
- FIFO:
  - 18 bits wide: data, last, err. First-word-fall-through: DOUT/DOUT_LAST/DOUT_ERR are valid whenever DOUT_VALID=1.
  - RD_EN while empty is ignored.
  - Simultaneous read and write: both occur and the count is unchanged.
  - A non-last word is dropped when count >= DEPTH-1, so one slot stays reserved for the closing word.
  - A last word is dropped only when count == DEPTH.
  - Each dropped word increments OVFL_CNT and marks the event errored.
  - If the last word itself is dropped, the event still closes (EVT_DONE); its last word is lost and OVFL_CNT records it.
- Error flag: the err bit is set on the last word of any event with a mux mismatch, drop, or timeout. Non-last words carry err=0.
- EVT_WRDS and EVT_MOVLP hold their values until the next EVT_DONE.
- Counters saturate at 255 and clear only on reset. EVT_WRDS saturates at 4095.

Test Plan:
- DATAAVAIL pulse, 4 valid words 0x0001..0x0004 with ENDWORD on the 4th, OVLPMUX_B consistent → FIFO holds 4 words, last flag on 0x0004, err=0, EVT_DONE once with EVT_WRDS=4, EVT_MOVLP=0.
- 3 valid words with no DATAAVAIL → nothing written, ORPHAN_CNT=3, FSM stays IDLE.
- DATAAVAIL, 2 words, then silence with TMO_CYC=16 → after 16 idle cycles trailer 0xDEAD written with last=1, err=1; TMO_CNT=1; EVT_DONE with EVT_WRDS=2.
- FIFO_AW=3, RD_EN=0, event of 10 words → 7 data words stored plus the last word (8 entries), OVFL_CNT=2, last word err=1.
- Event with OVLPMUX_B=DATAIN[14] on word 2 and MOVLP pulsed on word 3 → MUX_ERR_CNT=1, last word err=1, EVT_MOVLP=1.
- RST asserted mid-event after 5 words → DOUT_VALID=0 immediately, all counters 0; next full event is received cleanly.
